// File: rtl/logit_approx_if.sv
// Handshake bundle for the logit approximation core: y request channel and x result channel.
// The core takes the slave side; the producer/consumer takes the master side.
interface logit_approx_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] y_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] x_out;
    logic        range_err;
    logic        nan_flag;

    modport slave (
        input  in_valid, y_in, out_ready,
        output in_ready, out_valid, x_out, range_err, nan_flag
    );

    modport master (
        output in_valid, y_in, out_ready,
        input  in_ready, out_valid, x_out, range_err, nan_flag
    );
endinterface

// File: rtl/logit_approx.sv
// Inverse of the PLAN sigmoid: maps an IEEE-754 y in [0,1] back to x in [-5,+5].
// Multi-cycle FSM, one operation in flight, valid/ready on both sides.
module logit_approx #(
    parameter int          FRAC_BITS = 24,
    parameter logic [31:0] SAT_MAG   = 32'h40A00000
) (
    input  logic          clk,
    input  logic          rst_n,
    logit_approx_if.slave bus_io
);
    localparam int YW = FRAC_BITS + 1;
    localparam int MW = FRAC_BITS + 3;
    localparam int DW = FRAC_BITS + 4;

    localparam logic [DW-1:0] C_HALF  = DW'(1)  << (FRAC_BITS - 1);
    localparam logic [DW-1:0] C_5_8   = DW'(5)  << (FRAC_BITS - 3);
    localparam logic [DW-1:0] C_3_4   = DW'(3)  << (FRAC_BITS - 2);
    localparam logic [DW-1:0] C_27_32 = DW'(27) << (FRAC_BITS - 5);
    localparam logic [DW-1:0] C_59_64 = DW'(59) << (FRAC_BITS - 6);
    localparam logic [DW-1:0] C_MAX   = DW'(5)  << FRAC_BITS;
    localparam logic [YW-1:0] Y_ONE   = YW'(1)  << FRAC_BITS;
    localparam logic [31:0]   NEG_SAT = {1'b1, SAT_MAG[30:0]};
    localparam logic [31:0]   QNAN    = 32'h7FC00000;
    localparam logic [7:0]    MIN_EXP = 8'(127 - FRAC_BITS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_UNPACK,
        S_SEGMENT,
        S_COMPUTE,
        S_NORM,
        S_PACK,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   yIn_q, yIn_d;
    logic [YW-1:0] yFix_q, yFix_d;
    logic          neg_q, neg_d;
    logic [MW-1:0] mag_q, mag_d;
    logic [4:0]    shift_q, shift_d;
    logic          bypass_q, bypass_d;
    logic [31:0]   bypassX_q, bypassX_d;
    logic          rangePend_q, rangePend_d;
    logic          nanPend_q, nanPend_d;
    logic [31:0]   xOut_q, xOut_d;
    logic          rangeErr_q, rangeErr_d;
    logic          nanFlag_q, nanFlag_d;

    logic          ySign;
    logic [7:0]    yExp;
    logic [22:0]   yMant;
    logic          isNan, isNegative, isAboveOne, isTiny;
    logic [YW-1:0] yAligned, yScaled;
    logic [DW-1:0] yExt, mRaw;
    logic [MW-1:0] mClamped;

    assign ySign      = yIn_q[31];
    assign yExp       = yIn_q[30:23];
    assign yMant      = yIn_q[22:0];
    assign isNan      = (yExp == 8'hFF) && (yMant != '0);
    assign isNegative = ySign && (yIn_q[30:0] != '0);
    assign isAboveOne = !ySign && ((yExp > 8'd127) || ((yExp == 8'd127) && (yMant != '0)));
    assign isTiny     = yExp < MIN_EXP;
    assign yAligned   = YW'({1'b1, yMant}) << (FRAC_BITS - 23);
    assign yScaled    = yAligned >> (8'd127 - yExp);

    // Segment slopes are powers of two, so the multiply is a left shift of the offset.
    assign yExt     = DW'(yFix_q);
    assign mRaw     = (yExt < C_3_4)   ? ((yExt - C_HALF)  << 2) :
                      (yExt < C_59_64) ? ((yExt - C_5_8)   << 3) :
                                         ((yExt - C_27_32) << 5);
    assign mClamped = (mRaw > C_MAX) ? C_MAX[MW-1:0] : mRaw[MW-1:0];

    always_comb begin
        state_d     = state_q;
        yIn_d       = yIn_q;
        yFix_d      = yFix_q;
        neg_d       = neg_q;
        mag_d       = mag_q;
        shift_d     = shift_q;
        bypass_d    = bypass_q;
        bypassX_d   = bypassX_q;
        rangePend_d = rangePend_q;
        nanPend_d   = nanPend_q;
        xOut_d      = xOut_q;
        rangeErr_d  = rangeErr_q;
        nanFlag_d   = nanFlag_q;

        case (state_q)
            S_IDLE: begin
                if (bus_io.in_valid) begin
                    yIn_d       = bus_io.y_in;
                    bypass_d    = 1'b0;
                    rangePend_d = 1'b0;
                    nanPend_d   = 1'b0;
                    shift_d     = '0;
                    neg_d       = 1'b0;
                    state_d     = S_UNPACK;
                end
            end
            S_UNPACK: begin
                state_d = S_SEGMENT;
                if (isNan) begin
                    bypass_d  = 1'b1;
                    bypassX_d = QNAN;
                    nanPend_d = 1'b1;
                end else if (isNegative) begin
                    bypass_d    = 1'b1;
                    bypassX_d   = NEG_SAT;
                    rangePend_d = 1'b1;
                end else if (isAboveOne) begin
                    bypass_d    = 1'b1;
                    bypassX_d   = SAT_MAG;
                    rangePend_d = 1'b1;
                end else if (isTiny) begin
                    yFix_d = '0;
                end else begin
                    yFix_d = yScaled;
                end
            end
            S_SEGMENT: begin
                // Below one half, use the sigmoid symmetry and negate the result later.
                state_d = S_COMPUTE;
                if (yFix_q[YW-1:YW-2] == 2'b00) begin
                    yFix_d = Y_ONE - yFix_q;
                    neg_d  = 1'b1;
                end
            end
            S_COMPUTE: begin
                if (bypass_q) begin
                    state_d = S_PACK;
                end else if (yFix_q >= Y_ONE) begin
                    bypass_d  = 1'b1;
                    bypassX_d = neg_q ? NEG_SAT : SAT_MAG;
                    state_d   = S_PACK;
                end else if (mClamped == '0) begin
                    bypass_d  = 1'b1;
                    bypassX_d = '0;
                    state_d   = S_PACK;
                end else begin
                    mag_d   = mClamped;
                    state_d = S_NORM;
                end
            end
            S_NORM: begin
                if (mag_q[MW-1]) begin
                    state_d = S_PACK;
                end else begin
                    mag_d   = mag_q << 1;
                    shift_d = shift_q + 5'd1;
                end
            end
            S_PACK: begin
                xOut_d     = bypass_q ? bypassX_q
                                      : {neg_q, 8'd129 - {3'b000, shift_q}, mag_q[MW-2 -: 23]};
                rangeErr_d = rangePend_q;
                nanFlag_d  = nanPend_q;
                state_d    = S_DONE;
            end
            S_DONE: begin
                if (bus_io.out_ready) begin
                    rangeErr_d = 1'b0;
                    nanFlag_d  = 1'b0;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            yIn_q       <= '0;
            yFix_q      <= '0;
            neg_q       <= 1'b0;
            mag_q       <= '0;
            shift_q     <= '0;
            bypass_q    <= 1'b0;
            bypassX_q   <= '0;
            rangePend_q <= 1'b0;
            nanPend_q   <= 1'b0;
            xOut_q      <= '0;
            rangeErr_q  <= 1'b0;
            nanFlag_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            yIn_q       <= yIn_d;
            yFix_q      <= yFix_d;
            neg_q       <= neg_d;
            mag_q       <= mag_d;
            shift_q     <= shift_d;
            bypass_q    <= bypass_d;
            bypassX_q   <= bypassX_d;
            rangePend_q <= rangePend_d;
            nanPend_q   <= nanPend_d;
            xOut_q      <= xOut_d;
            rangeErr_q  <= rangeErr_d;
            nanFlag_q   <= nanFlag_d;
        end
    end

    // in_ready is gated by reset so the core never advertises idle while held in reset.
    assign bus_io.in_ready  = rst_n && (state_q == S_IDLE);
    assign bus_io.out_valid = (state_q == S_DONE);
    assign bus_io.x_out     = xOut_q;
    assign bus_io.range_err = rangeErr_q;
    assign bus_io.nan_flag  = nanFlag_q;
endmodule
